mem_arbiter: RTL and testbench

- Two-port arbiter sharing the single MemController/Ram path between the Control fetch unit (read-only) and the Control data path (read/write).
- Sits between Control and MemController. Drives MemController's Valid/RW/Addr/Data and consumes its ready/Data_in.
- Round-robin fairness between the two ports.
- Per-transaction timeout so a stalled memory cannot hang the processor.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter with per-transaction timeout in front of MemController
// Ports: clk/reset; fetch port f_req/f_addr -> f_ack/f_err/f_rdata; data port d_req/d_rw/d_addr/d_wdata
// -> d_ack/d_err/d_rdata; memory side m_valid/m_rw/m_addr/m_wdata -> m_ready/m_rdata; status busy/grant.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              grant
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]    state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          pick_d;
  logic          finish;
  // data wins when alone, or on a tie when fetch owned the previous transaction
  always_comb pick_d = d_req & (~f_req | ~last_grant);
  // m_ready takes priority over a coincident timeout
  always_comb finish = m_ready | (cnt == CW'(TIMEOUT - 1));
  // m_rw/m_addr/m_wdata double as the holding registers latched at grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      m_valid    <= 1'b0;
      m_rw       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      f_ack      <= 1'b0;
      f_err      <= 1'b0;
      f_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: if (f_req | d_req) begin
          state      <= ISSUE;
          busy       <= 1'b1;
          grant      <= pick_d;
          last_grant <= pick_d;
          m_valid    <= 1'b1;
          m_rw       <= pick_d & d_rw;
          m_addr     <= pick_d ? d_addr : f_addr;
          m_wdata    <= pick_d ? d_wdata : '0;
        end
        ISSUE: begin
          state   <= WAIT;
          m_valid <= 1'b0;
          cnt     <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (finish) begin
            state <= DONE;
            if (grant) begin
              d_ack   <= 1'b1;
              d_err   <= ~m_ready;
              d_rdata <= m_ready ? m_rdata : '0;
            end else begin
              f_ack   <= 1'b1;
              f_err   <= ~m_ready;
              f_rdata <= m_ready ? m_rdata : '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          f_ack <= 1'b0;
          f_err <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;
  logic        clk = 0;
  logic        reset = 1;
  logic        f_req = 0, d_req = 0, d_rw = 0;
  logic [7:0]  f_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic        f_ack, f_err, d_ack, d_err;
  logic [31:0] f_rdata, d_rdata;
  logic        m_valid, m_rw, m_ready;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        busy, grant;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  typedef struct {
    logic        port;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;
  exp_t q[$];

  logic [31:0] ram [256];
  logic        mem_off = 0;
  int          mem_lat = 1;

  // memory: answers mem_lat cycles after seeing m_valid (1 = first WAIT cycle)
  initial begin
    bit pend;
    int wc;
    logic [7:0] pa;
    logic pr;
    logic [31:0] pw;
    pend = 0; wc = 0; pa = 0; pr = 0; pw = 0;
    m_ready = 0;
    m_rdata = 0;
    forever begin
      @(negedge clk);
      m_ready = 0;
      if (mem_off) pend = 0;
      else if (pend) begin
        if (wc <= 1) begin
          m_ready = 1;
          if (pr) begin ram[pa] = pw; m_rdata = 0; end
          else m_rdata = ram[pa];
          pend = 0;
        end else wc--;
      end
      if (m_valid && !mem_off) begin
        pend = 1; wc = mem_lat; pa = m_addr; pr = m_rw; pw = m_wdata;
      end
    end
  end

  // monitor: checks each issue and each ack against the scoreboard front
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("m_valid_pulse", prev_v, 0);
        chk("issue_queued", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("issue_rw", m_rw, q[0].rw);
          chk("issue_addr", m_addr, q[0].addr);
          if (q[0].rw) chk("issue_wdata", m_wdata, q[0].wdata);
        end
      end
      prev_v = m_valid;
      if (f_ack || d_ack) begin
        chk("ack_queued", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ack_port", d_ack, e.port);
          chk("ack_single", f_ack & d_ack, 0);
          chk("ack_grant", grant, e.port);
          chk("ack_addr_held", m_addr, e.addr);
          chk("ack_err", e.port ? d_err : f_err, e.err);
          if (e.chk_rd) chk("ack_rdata", e.port ? d_rdata : f_rdata, e.rdata);
        end
      end
    end
  end

  task automatic push(input logic p, input logic rw, input logic [7:0] a, input logic [31:0] w,
                      input logic [31:0] r, input logic cr, input logic er);
    exp_t e;
    e.port = p; e.rw = rw; e.addr = a; e.wdata = w; e.rdata = r; e.chk_rd = cr; e.err = er;
    q.push_back(e);
  endtask

  // waits for the port's ack, drops its req on that cycle; dly = ack cycle - ISSUE cycle
  task automatic do_txn(input logic port, output int dly);
    int t0;
    bit got;
    t0 = -1; got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (m_valid && t0 < 0) t0 = cyc;
      if (port ? d_ack : f_ack) begin
        got = 1;
        if (port) d_req = 0; else f_req = 0;
      end
    end
    chk("ack_arrived", got, 1);
    dly = got ? cyc - t0 : -1;
    @(negedge clk);
  endtask

  task automatic d_start(input logic rw, input logic [7:0] a, input logic [31:0] w);
    d_rw = rw; d_addr = a; d_wdata = w; d_req = 1;
  endtask

  initial begin
    int dly, nf, nd;
    bit rf, rd;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'hFA] = 32'hDEADBEEF;
    ram[8'h20] = 32'hA0A0A0A0;
    ram[8'h30] = 32'hB0B0B0B0;
    ram[8'h40] = 32'h55AA55AA;
    ram[8'h60] = 32'h60606060;
    ram[8'h70] = 32'h70707070;
    ram[8'h81] = 32'h11111111;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {f_ack, d_ack, f_err, d_err}, 0);
    chk("rst_m_addr", m_addr, 0);
    reset = 0;

    // fetch read
    push(0, 0, 8'hFA, 0, 32'hDEADBEEF, 1, 0);
    f_addr = 8'hFA; f_req = 1;
    do_txn(0, dly);
    chk("fetch_ack_latency", dly, 2);

    // data write then read back
    push(1, 1, 8'h10, 32'h12345678, 0, 0, 0);
    d_start(1, 8'h10, 32'h12345678);
    do_txn(1, dly);
    push(1, 0, 8'h10, 0, 32'h12345678, 1, 0);
    d_start(0, 8'h10, 0);
    do_txn(1, dly);

    // inputs changed after grant are ignored
    mem_lat = 3;
    push(1, 1, 8'h80, 32'hCAFEF00D, 0, 0, 0);
    d_start(1, 8'h80, 32'hCAFEF00D);
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    @(negedge clk);
    d_addr = 8'h81; d_wdata = 32'h0;
    do_txn(1, dly);
    push(1, 0, 8'h80, 0, 32'hCAFEF00D, 1, 0);
    d_start(0, 8'h80, 0);
    do_txn(1, dly);
    push(1, 0, 8'h81, 0, 32'h11111111, 1, 0);
    d_start(0, 8'h81, 0);
    do_txn(1, dly);

    // timeout with silent memory
    mem_off = 1;
    push(1, 0, 8'h40, 0, 32'h0, 1, 1);
    d_start(0, 8'h40, 0);
    do_txn(1, dly);
    chk("timeout_latency", dly, 16);
    chk("timeout_busy_after", busy, 0);

    // memory answers on the 15th WAIT cycle: ready beats timeout
    mem_off = 0; mem_lat = 15;
    push(1, 0, 8'h40, 0, 32'h55AA55AA, 1, 0);
    d_start(0, 8'h40, 0);
    do_txn(1, dly);
    chk("late_ready_latency", dly, 16);

    // contention from reset: strict alternation starting with fetch
    mem_lat = 1;
    reset = 1;
    f_addr = 8'h20; d_rw = 0; d_addr = 8'h30;
    f_req = 1; d_req = 1;
    push(0, 0, 8'h20, 0, 32'hA0A0A0A0, 1, 0);
    push(1, 0, 8'h30, 0, 32'hB0B0B0B0, 1, 0);
    push(0, 0, 8'h20, 0, 32'hA0A0A0A0, 1, 0);
    push(1, 0, 8'h30, 0, 32'hB0B0B0B0, 1, 0);
    @(negedge clk);
    reset = 0;
    nf = 0; nd = 0; rf = 0; rd = 0;
    for (int i = 0; i < 200 && nf + nd < 4; i++) begin
      @(negedge clk);
      if (rf) begin f_req = 1; rf = 0; end
      if (rd) begin d_req = 1; rd = 0; end
      if (f_ack) begin nf++; f_req = 0; rf = nf < 2; end
      if (d_ack) begin nd++; d_req = 0; rd = nd < 2; end
    end
    chk("contention_fetch_acks", nf, 2);
    chk("contention_data_acks", nd, 2);
    @(negedge clk);

    // reset during WAIT aborts without an ack
    mem_off = 1;
    push(0, 0, 8'h50, 0, 0, 0, 0);
    f_addr = 8'h50; f_req = 1;
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1; f_req = 0;
    @(negedge clk);
    reset = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_addr", m_addr, 0);
    chk("midrst_acks", {f_ack, d_ack}, 0);
    chk("midrst_rdata", {f_rdata, d_rdata}, 0);
    chk("midrst_grant", grant, 0);
    q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_late_ack", {f_ack, d_ack, busy}, 0);

    // first tie after reset goes to fetch
    mem_off = 0; mem_lat = 2;
    push(0, 0, 8'h60, 0, 32'h60606060, 1, 0);
    push(1, 0, 8'h70, 0, 32'h70707070, 1, 0);
    f_addr = 8'h60; d_start(0, 8'h70, 0); f_req = 1;
    do_txn(0, dly);
    do_txn(1, dly);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
